// File: rtl/fifo_pkg.sv
// Shared FIFO2 constants and types: default geometry and almost-full level
// used by the datapath blocks and their sequencer.
package fifo_pkg;

  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_ADDR_W   = 3;
  localparam int FIFO_AF_LEVEL = 6;
  localparam int FIFO_CNT_W    = FIFO_ADDR_W + 1;

  typedef logic [FIFO_ADDR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0]  count_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the producer/consumer side (master) and the
// FIFO2 sequencer (slave). Clock and reset stay outside as plain ports.
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wr_req;
  logic              rd_req;
  logic              err_clr;
  logic [DEPTH-1:0]  wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              wr_ack;
  logic              rd_ack;
  logic              ovf;
  logic              udf;

  modport master (
    output wr_req, rd_req, err_clr,
    input  wr_en, waddr, raddr, count, full, empty, almost_full,
           wr_ack, rd_ack, ovf, udf
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output wr_en, waddr, raddr, count, full, empty, almost_full,
           wr_ack, rd_ack, ovf, udf
  );

endinterface

// File: rtl/fifo_wr_decode.sv
// Write-pointer to one-hot word-enable decoder for the edge_dff storage array.
// Output is all-zero unless enabled, so at most one word is written per edge.
module fifo_wr_decode
  import fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot
);

  // Select the single word addressed by the write pointer.
  always_comb begin
    // NOTE: default every bit first so no path through the block leaves the
    // output unassigned, which would infer a latch.
    onehot       = '0;
    onehot[addr] = en;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO2 control sequencer: write/read pointers, occupancy count, status flags
// and sticky error flags. Data never passes through here; the storage array
// takes wr_en/waddr and reads through the mux addressed by raddr.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic      clk,
  input  logic      clear_n,
  fifo_ctrl_if.slave bus
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(AF_LEVEL);

  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              udf_q;

  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              rd_ack;
  logic [DEPTH-1:0]  wr_en;

  // Flags decode the registered count, so they move one cycle after the
  // accepting edge.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Accepts use this cycle's registered flags. The write accept is also
  // gated by clear_n so no word enable can fire while reset is held.
  assign wr_ack = bus.wr_req & ~full & clear_n;
  assign rd_ack = bus.rd_req & ~empty;

  fifo_wr_decode #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wr_decode (
    .en     (wr_ack),
    .addr   (waddr_q),
    .onehot (wr_en)
  );

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge clear_n) begin
    // NOTE: only control state is reset here; the storage words themselves
    // are abandoned on reset and simply overwritten by later writes.
    if (!clear_n) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the order of these statements does not matter.
      if (wr_ack) waddr_q <= waddr_q + ADDR_W'(1);
      if (rd_ack) raddr_q <= raddr_q + ADDR_W'(1);
      if (wr_ack && !rd_ack)      count_q <= count_q + CNT_W'(1);
      else if (rd_ack && !wr_ack) count_q <= count_q - CNT_W'(1);
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_req && full)  ovf_q <= 1'b1;
      else if (bus.err_clr)    ovf_q <= 1'b0;
      if (bus.rd_req && empty) udf_q <= 1'b1;
      else if (bus.err_clr)    udf_q <= 1'b0;
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.waddr       = waddr_q;
  assign bus.raddr       = raddr_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count_q >= CNT_AF);
  assign bus.wr_ack      = wr_ack;
  assign bus.rd_ack      = rd_ack;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl. Each vector drives one cycle of requests and
// queues the hand-computed outputs expected during that cycle; a monitor on
// the falling edge pops and compares them.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  typedef struct {
    logic [7:0] wr_en;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic [3:0] count;
    logic [6:0] flags; // {full, empty, almost_full, wr_ack, rd_ack, ovf, udf}
  } exp_t;

  logic clk = 1'b0;
  logic clear_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fifo_ctrl_if #(.DEPTH(8), .ADDR_W(3)) bus ();

  fifo_ctrl #(.DEPTH(8), .ADDR_W(3), .AF_LEVEL(6)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. pulse=1 drops clear_n between edges and releases
  // it before the next rising edge.
  task automatic vec(input logic wr, input logic rd, input logic ec, input logic pulse,
                     input logic [7:0] e_wren, input logic [2:0] e_wa, input logic [2:0] e_ra,
                     input logic [3:0] e_cnt, input logic [6:0] e_flags);
    exp_t e;
    @(posedge clk);
    #1;
    clear_n     = ~pulse;
    bus.wr_req  = wr;
    bus.rd_req  = rd;
    bus.err_clr = ec;
    e.wr_en = e_wren; e.waddr = e_wa; e.raddr = e_ra; e.count = e_cnt; e.flags = e_flags;
    exp_q.push_back(e);
    if (pulse) begin
      @(negedge clk);
      #1;
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.err_clr = 1'b0;
      clear_n     = 1'b1;
    end
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_en",       bus.wr_en,       e.wr_en);
        check("waddr",       bus.waddr,       e.waddr);
        check("raddr",       bus.raddr,       e.raddr);
        check("count",       bus.count,       e.count);
        check("full",        bus.full,        e.flags[6]);
        check("empty",       bus.empty,       e.flags[5]);
        check("almost_full", bus.almost_full, e.flags[4]);
        check("wr_ack",      bus.wr_ack,      e.flags[3]);
        check("rd_ack",      bus.rd_ack,      e.flags[2]);
        check("ovf",         bus.ovf,         e.flags[1]);
        check("udf",         bus.udf,         e.flags[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_n     = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;

    // Reset state
    vec(0,0,0,0, 8'h00, 0,0,0, 7'b0100000);

    // Eight writes: count 0..7 shown, almost_full from count 6, one-hot enables
    vec(1,0,0,0, 8'h01, 0,0,0, 7'b0101000);
    vec(1,0,0,0, 8'h02, 1,0,1, 7'b0001000);
    vec(1,0,0,0, 8'h04, 2,0,2, 7'b0001000);
    vec(1,0,0,0, 8'h08, 3,0,3, 7'b0001000);
    vec(1,0,0,0, 8'h10, 4,0,4, 7'b0001000);
    vec(1,0,0,0, 8'h20, 5,0,5, 7'b0001000);
    vec(1,0,0,0, 8'h40, 6,0,6, 7'b0011000);
    vec(1,0,0,0, 8'h80, 7,0,7, 7'b0011000);

    // Full: write refused, ovf next cycle, cleared by err_clr
    vec(1,0,0,0, 8'h00, 0,0,8, 7'b1010000);
    vec(0,0,0,0, 8'h00, 0,0,8, 7'b1010010);
    vec(0,0,1,0, 8'h00, 0,0,8, 7'b1010010);
    // Set and clear together: set wins
    vec(1,0,1,0, 8'h00, 0,0,8, 7'b1010000);
    vec(0,0,0,0, 8'h00, 0,0,8, 7'b1010010);
    vec(0,0,1,0, 8'h00, 0,0,8, 7'b1010010);

    // Full with simultaneous requests: read only, ovf set
    vec(1,1,0,0, 8'h00, 0,0,8, 7'b1010100);
    vec(0,0,0,0, 8'h00, 0,1,7, 7'b0010010);
    vec(0,0,1,0, 8'h00, 0,1,7, 7'b0010010);

    // Drain to count 4
    vec(0,1,0,0, 8'h00, 0,1,7, 7'b0010100);
    vec(0,1,0,0, 8'h00, 0,2,6, 7'b0010100);
    vec(0,1,0,0, 8'h00, 0,3,5, 7'b0000100);

    // Ten simultaneous requests at count 4: count holds, pointers move by 10
    for (int i = 0; i < 10; i++)
      vec(1,1,0,0, 8'(1 << (i % 8)), 3'(i % 8), 3'((4 + i) % 8), 4'd4, 7'b0001100);
    vec(0,0,0,0, 8'h00, 2,6,4, 7'b0000000);

    // Drain to empty
    vec(0,1,0,0, 8'h00, 2,6,4, 7'b0000100);
    vec(0,1,0,0, 8'h00, 2,7,3, 7'b0000100);
    vec(0,1,0,0, 8'h00, 2,0,2, 7'b0000100);
    vec(0,1,0,0, 8'h00, 2,1,1, 7'b0000100);

    // Empty with simultaneous requests: write only, udf set, raddr unchanged
    vec(1,1,0,0, 8'h04, 2,2,0, 7'b0101000);
    vec(0,0,0,0, 8'h00, 3,2,1, 7'b0000001);
    vec(0,0,1,0, 8'h00, 3,2,1, 7'b0000001);

    // Walk to count 5 with waddr 3, raddr 6
    vec(0,1,0,0, 8'h00, 3,2,1, 7'b0000100);
    vec(1,0,0,0, 8'h08, 3,3,0, 7'b0101000);
    vec(0,1,0,0, 8'h00, 4,3,1, 7'b0000100);
    vec(1,0,0,0, 8'h10, 4,4,0, 7'b0101000);
    vec(0,1,0,0, 8'h00, 5,4,1, 7'b0000100);
    vec(1,0,0,0, 8'h20, 5,5,0, 7'b0101000);
    vec(0,1,0,0, 8'h00, 6,5,1, 7'b0000100);
    vec(1,0,0,0, 8'h40, 6,6,0, 7'b0101000);
    vec(1,0,0,0, 8'h80, 7,6,1, 7'b0001000);
    vec(1,0,0,0, 8'h01, 0,6,2, 7'b0001000);
    vec(1,0,0,0, 8'h02, 1,6,3, 7'b0001000);
    vec(1,0,0,0, 8'h04, 2,6,4, 7'b0001000);
    vec(0,0,0,0, 8'h00, 3,6,5, 7'b0000000);

    // Mid-cycle reset with a write pending: everything back to reset values
    vec(1,0,0,1, 8'h00, 0,0,0, 7'b0100000);
    vec(0,0,0,0, 8'h00, 0,0,0, 7'b0100000);
    // First accept after release
    vec(1,0,0,0, 8'h01, 0,0,0, 7'b0101000);
    vec(0,0,0,0, 8'h00, 1,0,1, 7'b0000000);

    @(posedge clk);
    #1;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous control sequencer for the FIFO2 storage array, which is built from `edge_dff` word registers. It holds the write and read pointers and the occupancy count. It decodes per-word write enables for the storage cells and supplies the read-mux address. It also generates the full, empty and almost-full flags and sticky overflow/underflow error flags. It sits between the producer/consumer request interface and the flop array; no data passes through it.

## Interface
Parameters:
- `DEPTH`, 8: number of storage words. Power of two, ≥ 2.
- `ADDR_W`, 3: log2(`DEPTH`).
- `AF_LEVEL`, 6: almost-full threshold on count. Range 1..`DEPTH`.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `clear_n`, in, 1: reset, asynchronous assert, active-low.
- `wr_req`, in, 1: producer write request for this cycle.
- `rd_req`, in, 1: consumer read request for this cycle.
- `err_clr`, in, 1: synchronous clear of the sticky error flags.
- `wr_en`, out, `DEPTH`: one-hot word write enable to the storage array. Combinational.
- `waddr`, out, `ADDR_W`: current write pointer. Registered.
- `raddr`, out, `ADDR_W`: current read pointer, drives the storage read mux. Registered.
- `count`, out, `ADDR_W`+1: occupancy, 0..`DEPTH`. Registered.
- `full`, out, 1: `count` == `DEPTH`.
- `empty`, out, 1: `count` == 0.
- `almost_full`, out, 1: `count` ≥ `AF_LEVEL`.
- `wr_ack`, out, 1: write accepted this cycle. Combinational.
- `rd_ack`, out, 1: read accepted this cycle. Combinational.
- `ovf`, out, 1: sticky overflow error.
- `udf`, out, 1: sticky underflow error.

## Operation
- Reset values (`clear_n` = 0, asynchronous): `waddr` = 0, `raddr` = 0, `count` = 0, `empty` = 1, `full` = 0, `almost_full` = 0, `ovf` = 0, `udf` = 0. `wr_en` is all-zero while reset is held.
- Accept rules: `wr_ack` = `wr_req` & !`full`; `rd_ack` = `rd_req` & !`empty`. Both use the registered flags of the current cycle.
- `wr_en[waddr]` = `wr_ack`; all other bits are 0. At most one bit is ever set.
- Pointer update: `waddr` increments on `wr_ack`, and `raddr` increments on `rd_ack`. Both are modulo `DEPTH`, wrapping from `DEPTH`-1 to 0 with no extra state.
- Count update: +1 on `wr_ack` only, −1 on `rd_ack` only, unchanged when both or neither.
- Simultaneous requests:
  - Non-empty, non-full: both are accepted and `count` holds.
  - `full`: read only; the write is refused and `ovf` is set.
  - `empty`: write only, with no fall-through; the read is refused and `udf` is set.
- Errors: `ovf` sets on `wr_req` & `full`. `udf` sets on `rd_req` & `empty`. Both hold until `err_clr` or reset. If set and clear happen in the same cycle, set wins.
- Flags are derived from the registered `count`, so they change exactly one cycle after the accepting edge.
- No state machine beyond the count/pointer registers. The invariant `waddr` − `raddr` ≡ `count` mod `DEPTH` always holds.

## Timing
- Write latency: data on the storage D inputs is captured at the edge where `wr_en` is high. It becomes readable at `raddr` from the next cycle, and `empty` falls on that same cycle.
- Read: storage output at `raddr` is valid combinationally while !`empty`. The consumer samples it in the cycle where `rd_ack` = 1, and the pointer advances on that edge.
- Reset mid-operation: all pointers and the count return to 0 immediately. Stored words are abandoned and not cleared by this block.
- Release of `clear_n` is synchronised externally. The first accept can occur on the first rising edge after release.

## Structure
- Shared package `fifo_pkg`: default `DEPTH`/`ADDR_W`/`AF_LEVEL` constants and the count width constant (`ADDR_W`+1). FIFO2 datapath blocks share it.
- Sub-module `fifo_wr_decode`: `ADDR_W`-to-`DEPTH` one-hot decoder with an enable input, generating `wr_en`.
- Top level holds the pointer, count and error registers plus the accept logic.

## Test plan
- Reset, then 8 writes with no reads → `count` steps 1..8, `almost_full` rises when `count` = 6, `full` = 1 after the 8th, `waddr` = 0 (wrapped), `wr_en` one-hot 0x01, 0x02 … 0x80.
- Full, then `wr_req` = 1, `rd_req` = 0 → `wr_ack` = 0, `wr_en` = 0, `ovf` = 1 next cycle, `count` stays 8. Assert `err_clr` → `ovf` = 0.
- Empty, then `wr_req` = `rd_req` = 1 → write only, `rd_ack` = 0, `udf` = 1, `count` = 1, `raddr` = 0.
- `count` = 4, then `wr_req` = `rd_req` = 1 for 10 cycles → `count` stays 4, both pointers advance by 10 mod 8 = 2, no flag toggles.
- Full, then simultaneous requests → read only, `count` = 7, `full` = 0 next cycle, `ovf` = 1.
- `count` = 5 with pointers at 3/6, then `clear_n` pulsed low between edges → all outputs return to reset values immediately and stay there until the first edge after release.
